dpram_req_adapter: RTL

//  Request/response front end for the 32-bit testbench RAM model (1-cycle registered read, full-word write).

---
 rtl/dpram_req_if.sv | 28 ++
 rtl/dpram_req_adapter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dpram_req_if.sv
// Core-side request/response bus between a core and dpram_req_adapter.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready,
// and a response transfers on an edge where resp_valid && resp_ready. Each producer
// holds valid and its payload stable until that edge; ready may change at any time.
interface dpram_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Core side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Adapter side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dpram_req_adapter.sv
// Request/response front end for a 32-bit RAM with 1-cycle registered read and
// full-word write. One request in flight; range/alignment checked; byte-enable
// writes done by read-modify-write.
// Optional feature macro: DPRAM_RMW_EN. When undefined, partial byte-enable
// writes are rejected with an error response and the MERGE state is absent.
module dpram_req_adapter #(
  parameter int unsigned SIZE      = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  dpram_req_if.slave  bus,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [2:0]  dbg_state
);

  localparam logic [31:0] LAST_OFF = 32'(SIZE - 4);

`ifdef DPRAM_RMW_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    MERGE = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;
`endif

  state_t      state;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] offset_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        ready;
  logic        accept;
  logic [31:0] offset_in;
  logic        req_bad;

  assign ready     = (state == IDLE) && !resp_valid_q && !rst;
  assign accept    = bus.req_valid && ready;
  assign offset_in = bus.req_addr - BASE_ADDR;

  // Classify the incoming request: misaligned, below the window, or past the last word.
  always_comb begin
    req_bad = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) ||
              (offset_in > LAST_OFF);
`ifndef DPRAM_RMW_EN
    // Without read-modify-write a partial write cannot be honoured.
    if (bus.req_we && (bus.req_be != 4'h0) && (bus.req_be != 4'hF)) req_bad = 1'b1;
`endif
  end

`ifdef DPRAM_RMW_EN
  logic [31:0] merged;

  // Overlay enabled write bytes onto the word read back during ISSUE.
  always_comb begin
    merged = mem_dout;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end
`endif

  // Request sequencing: accept, access RAM, then hold the response until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
      offset_q     <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q         <= bus.req_we;
            be_q         <= bus.req_be;
            wdata_q      <= bus.req_wdata;
            offset_q     <= offset_in;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= req_bad;
            if (req_bad) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!we_q) begin
            state <= CAPT;
`ifdef DPRAM_RMW_EN
          end else if ((be_q != 4'hF) && (be_q != 4'h0)) begin
            state <= MERGE;
`endif
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
          end
        end
`ifdef DPRAM_RMW_EN
        MERGE: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
        end
`endif
        CAPT: begin
          resp_rdata_q <= mem_dout;
          state        <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM write strobe decoded from state; rst suppresses a write in its own cycle.
  always_comb begin
    mem_we = 1'b0;
    if (!rst) begin
      if ((state == ISSUE) && we_q && (be_q == 4'hF)) mem_we = 1'b1;
`ifdef DPRAM_RMW_EN
      if (state == MERGE) mem_we = 1'b1;
`endif
    end
  end

  // Write data: the merged word during MERGE, otherwise the request word.
  always_comb begin
    mem_din = wdata_q;
`ifdef DPRAM_RMW_EN
    if (state == MERGE) mem_din = merged;
`endif
  end

  assign mem_waddr      = offset_q;
  assign mem_raddr      = offset_q;
  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign dbg_state      = state;

endmodule
